// File: rtl/gray_step_ctrl_pkg.sv
// Shared types and code-conversion helpers for the gray-code CDC path.
// The helpers work on a 32-bit container; callers zero-extend and truncate to their width.
package gray_step_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    MOVE   = 2'd1,
    FINISH = 2'd2
  } state_e;

  localparam int CODE_W = 32;

  function automatic logic [CODE_W-1:0] bin2gray(input logic [CODE_W-1:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [CODE_W-1:0] gray2bin(input logic [CODE_W-1:0] g);
    logic [CODE_W-1:0] b;
    b[CODE_W-1] = g[CODE_W-1];
    for (int i = CODE_W - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  function automatic int hold_width(input int hold);
    return $clog2(hold + 1);
  endfunction

endpackage

// File: rtl/gray_step_ctrl.sv
// Source-side sequencer: walks a registered counter one LSB at a time toward a
// requested target (shortest way round), holding each value HOLD cycles.
module gray_step_ctrl
  import gray_step_ctrl_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int HOLD  = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             tgt_valid,
  output logic             tgt_ready,
  input  logic [WIDTH-1:0] tgt_data,
  output logic [WIDTH-1:0] cnt_bin,
  output logic [WIDTH-1:0] cnt_gray,
  output logic             busy,
  output logic             done
);

  localparam int                HOLD_W      = hold_width(HOLD);
  localparam logic [HOLD_W-1:0] HOLD_RELOAD = HOLD_W'(HOLD - 1);

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   gray_q, gray_d;
  logic [WIDTH-1:0]   rem_q, rem_d;
  logic [HOLD_W-1:0]  hold_q, hold_d;
  logic               up_q, up_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  logic [WIDTH-1:0]   dist_up, dist_dn;
  logic               go_up;

  // Modular distances; a half-way tie resolves upward.
  assign dist_up = tgt_data - cnt_q;
  assign dist_dn = cnt_q - tgt_data;
  assign go_up   = (dist_up <= dist_dn);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    hold_d  = hold_q;
    up_d    = up_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (tgt_valid) begin
          up_d   = go_up;
          rem_d  = go_up ? dist_up : dist_dn;
          hold_d = '0;
          if (rem_d == '0) begin
            state_d = FINISH;
          end else begin
            state_d = MOVE;
            busy_d  = 1'b1;
          end
        end
      end
      MOVE: begin
        if (hold_q == '0) begin
          if (rem_q != '0) begin
            cnt_d  = up_q ? (cnt_q + WIDTH'(1)) : (cnt_q - WIDTH'(1));
            rem_d  = rem_q - WIDTH'(1);
            hold_d = HOLD_RELOAD;
          end
        end else begin
          hold_d = hold_q - HOLD_W'(1);
        end
        // Leave one cycle early so the registered done lands exactly HOLD after the last step.
        if (rem_d == '0 && hold_d == '0) begin
          state_d = FINISH;
        end
      end
      FINISH: begin
        state_d = IDLE;
        done_d  = 1'b1;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
    gray_d = WIDTH'(bin2gray(CODE_W'(cnt_d)));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      gray_q  <= '0;
      rem_q   <= '0;
      hold_q  <= '0;
      up_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      gray_q  <= gray_d;
      rem_q   <= rem_d;
      hold_q  <= hold_d;
      up_q    <= up_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign tgt_ready = (state_q == IDLE);
  assign cnt_bin   = cnt_q;
  assign cnt_gray  = gray_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_gray_step_ctrl.sv
// Bench for gray_step_ctrl: timeline-based reference model, per-cycle compare,
// directed literal pins, invariant checks and a randomized run.
module tb_gray_step_ctrl;

  localparam int WIDTH = 4;
  localparam int HOLD  = 3;
  localparam int MODN  = 1 << WIDTH;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             tgt_valid = 1'b0;
  logic [WIDTH-1:0] tgt_data = '0;
  logic             tgt_ready;
  logic [WIDTH-1:0] cnt_bin;
  logic [WIDTH-1:0] cnt_gray;
  logic             busy;
  logic             done;

  int nc = 0;
  int nf = 0;

  gray_step_ctrl #(.WIDTH(WIDTH), .HOLD(HOLD)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .tgt_valid (tgt_valid),
    .tgt_ready (tgt_ready),
    .tgt_data  (tgt_data),
    .cnt_bin   (cnt_bin),
    .cnt_gray  (cnt_gray),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nc++;
    if (act !== exp) begin
      nf++;
      $display("FAIL %s: got %0d, expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: every output is a function of edges elapsed since acceptance.
  logic [WIDTH-1:0] m_cnt = '0;
  logic [WIDTH-1:0] m_base = '0;
  logic [WIDTH-1:0] m_tgt = '0;
  bit m_up = 1'b0;
  bit m_act = 1'b0;
  bit m_busy = 1'b0;
  bit m_done = 1'b0;
  bit m_ready = 1'b1;
  int m_d = 0;
  int m_m = 0;
  int accepted = 0;
  int aborted = 0;
  int dones = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      if (m_act && m_m <= m_d * HOLD) aborted++;
      m_act   = 1'b0;
      m_cnt   = '0;
      m_busy  = 1'b0;
      m_done  = 1'b0;
      m_ready = 1'b1;
    end else begin
      if (m_ready && tgt_valid) begin
        int up, dn;
        up     = (int'(tgt_data) - int'(m_cnt) + MODN) % MODN;
        dn     = (MODN - up) % MODN;
        m_up   = (up <= dn);
        m_d    = m_up ? up : dn;
        m_base = m_cnt;
        m_tgt  = tgt_data;
        m_m    = 0;
        m_act  = 1'b1;
        accepted++;
      end else if (m_act) begin
        m_m++;
      end
      if (m_act && m_m > m_d * HOLD + 1) m_act = 1'b0;
      if (m_act) begin
        int k;
        k = (m_m >= 1) ? ((m_m - 1) / HOLD + 1) : 0;
        if (k > m_d) k = m_d;
        m_cnt   = m_up ? WIDTH'(int'(m_base) + k) : WIDTH'(int'(m_base) - k + MODN);
        m_busy  = (m_d > 0) && (m_m <= m_d * HOLD);
        m_done  = (m_m == m_d * HOLD + 1);
        m_ready = m_done;
      end else begin
        m_busy  = 1'b0;
        m_done  = 1'b0;
        m_ready = 1'b1;
      end
    end
  end

  // Per-cycle compare plus invariants, sampled on the inactive edge.
  logic [WIDTH-1:0] prev_gray = '0;
  bit prev_ok = 1'b0;
  int since = HOLD;

  always @(negedge clk) begin
    logic [WIDTH-1:0] exp_gray;
    exp_gray = m_cnt ^ (m_cnt >> 1);
    chk("cnt_bin", 32'(cnt_bin), 32'(m_cnt));
    chk("cnt_gray", 32'(cnt_gray), 32'(exp_gray));
    chk("busy", 32'(busy), 32'(m_busy));
    chk("done", 32'(done), 32'(m_done));
    chk("tgt_ready", 32'(tgt_ready), 32'(m_ready));
    if (rst_n && done === 1'b1) begin
      dones++;
      chk("final_value", 32'(cnt_bin), 32'(m_tgt));
    end
    if (!rst_n) begin
      prev_ok = 1'b0;
      since   = HOLD;
    end else begin
      if (prev_ok && cnt_gray !== prev_gray) begin
        chk("gray_single_bit", 32'($countones(cnt_gray ^ prev_gray)), 32'd1);
        chk("step_spacing_ok", 32'(since >= HOLD), 32'd1);
        since = 1;
      end else begin
        since++;
      end
      prev_ok = 1'b1;
    end
    prev_gray = cnt_gray;
  end

  task automatic adv(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Presents a request for one edge; returns at E0 + 1 time unit.
  task automatic accept(input logic [WIDTH-1:0] d);
    tgt_valid = 1'b1;
    tgt_data  = d;
    adv(1);
    tgt_valid = 1'b0;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_cnt_bin"}, 32'(cnt_bin), 32'd0);
    chk({tag, "_cnt_gray"}, 32'(cnt_gray), 32'd0);
    chk({tag, "_ready"}, 32'(tgt_ready), 32'd1);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_done"}, 32'(done), 32'd0);
  endtask

  initial begin
    adv(3);
    rst_n = 1'b1;
    adv(1);
    chk_reset_vals("reset");

    // 0 -> 3, stepping up
    accept(4'd3);
    adv(1);  chk("t3_m1_bin", 32'(cnt_bin), 32'd1); chk("t3_m1_gray", 32'(cnt_gray), 32'b0001);
    chk("t3_m1_busy", 32'(busy), 32'd1);
    adv(3);  chk("t3_m4_bin", 32'(cnt_bin), 32'd2); chk("t3_m4_gray", 32'(cnt_gray), 32'b0011);
    adv(3);  chk("t3_m7_bin", 32'(cnt_bin), 32'd3); chk("t3_m7_gray", 32'(cnt_gray), 32'b0010);
    adv(2);  chk("t3_m9_done", 32'(done), 32'd0); chk("t3_m9_busy", 32'(busy), 32'd1);
    adv(1);  chk("t3_m10_done", 32'(done), 32'd1); chk("t3_m10_busy", 32'(busy), 32'd0);
    chk("t3_m10_ready", 32'(tgt_ready), 32'd1);

    // 3 -> 14 accepted in the done cycle, stepping down through the wrap
    accept(4'd14);
    adv(7);  chk("t14_m7_gray", 32'(cnt_gray), 32'b0000);
    adv(3);  chk("t14_m10_bin", 32'(cnt_bin), 32'd15); chk("t14_m10_gray", 32'(cnt_gray), 32'b1000);
    adv(3);  chk("t14_m13_bin", 32'(cnt_bin), 32'd14);
    adv(2);  chk("t14_m15_done", 32'(done), 32'd0);
    adv(1);  chk("t14_m16_done", 32'(done), 32'd1);

    // 14 -> 0, then the tie case 0 -> 8
    accept(4'd0);
    adv(7);  chk("t0_m7_done", 32'(done), 32'd1); chk("t0_m7_bin", 32'(cnt_bin), 32'd0);
    accept(4'd8);
    adv(1);  chk("t8_m1_bin", 32'(cnt_bin), 32'd1);
    adv(21); chk("t8_m22_bin", 32'(cnt_bin), 32'd8);
    adv(2);  chk("t8_m24_done", 32'(done), 32'd0);
    adv(1);  chk("t8_m25_done", 32'(done), 32'd1);

    // 8 -> 5, then a zero-distance request
    accept(4'd5);
    adv(10); chk("t5_done", 32'(done), 32'd1);
    accept(4'd5);
    chk("d0_m0_busy", 32'(busy), 32'd0); chk("d0_m0_done", 32'(done), 32'd0);
    adv(1);  chk("d0_m1_done", 32'(done), 32'd1); chk("d0_m1_busy", 32'(busy), 32'd0);
    chk("d0_m1_bin", 32'(cnt_bin), 32'd5);

    // 5 -> 2 with a competing request that must be ignored
    accept(4'd2);
    adv(2);
    tgt_valid = 1'b1; tgt_data = 4'd9;
    adv(3);
    tgt_valid = 1'b0;
    adv(5);  chk("ign_done", 32'(done), 32'd1); chk("ign_bin", 32'(cnt_bin), 32'd2);

    // 2 -> 12 (down through 0 to 15), reset asserted mid-move
    accept(4'd12);
    adv(8);  chk("rst_pre_bin", 32'(cnt_bin), 32'd15); chk("rst_pre_gray", 32'(cnt_gray), 32'b1000);
    rst_n = 1'b0;
    #1;
    chk_reset_vals("async_rst");
    adv(2);
    rst_n = 1'b1;
    adv(1);

    // Randomized requests and valid timing
    for (int i = 0; i < 10000; i++) begin
      tgt_valid = ($urandom_range(0, 3) == 0);
      tgt_data  = WIDTH'($urandom);
      adv(1);
    end
    tgt_valid = 1'b0;
    adv(30);

    chk("done_per_request", 32'(dones), 32'(accepted - aborted));
    chk("requests_seen", 32'(accepted > 100), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nc, nf);
    $finish;
  end

endmodule
